// File: rtl/dma_wr_sched_pkg.sv
// Shared types and helpers for the DMA write scheduler.
package dma_wr_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_ACK,
    XFER,
    REPORT
  } state_t;

  // Width of a channel index; never narrower than one bit.
  function automatic int unsigned ch_id_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter; the caller owns the last-grant register.
module rr_arbiter
  import dma_wr_sched_pkg::*;
#(
  parameter  int unsigned N   = 4,
  localparam int unsigned IDW = ch_id_w(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] last,
  output logic [N-1:0]   gnt_onehot,
  output logic [IDW-1:0] gnt_id,
  output logic           any
);

  logic           found;
  logic [IDW-1:0] idx;

  // Scan starting one past the last winner and take the first requester found.
  always_comb begin
    gnt_onehot = '0;
    gnt_id     = '0;
    any        = |req;
    found      = 1'b0;
    idx        = '0;
    for (int unsigned i = 0; i < N; i++) begin
      idx = IDW'((32'(last) + 32'd1 + i) % N);
      if (!found && req[idx]) begin
        found           = 1'b1;
        gnt_onehot[idx] = 1'b1;
        gnt_id          = idx;
      end
    end
  end

endmodule

// File: rtl/dma_wr_sched.sv
// Shares one DMA write engine among NUM_CH requesters: round-robin command
// arbitration, stream steering, beat metering and per-channel done/err report.
module dma_wr_sched
  import dma_wr_sched_pkg::*;
#(
  parameter  int unsigned NUM_CH     = 4,
  parameter  int unsigned DATA_WIDTH = 1024,
  parameter  int unsigned ADDR_WIDTH = 32,
  localparam int unsigned IDW        = ch_id_w(NUM_CH),
  localparam int unsigned KW         = DATA_WIDTH / 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  // per-channel command
  input  logic [NUM_CH-1:0]            req_vld,
  output logic [NUM_CH-1:0]            req_rdy,
  input  logic [NUM_CH*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_CH*32-1:0]         req_size,
  input  logic [NUM_CH-1:0]            req_eof,
  output logic [NUM_CH-1:0]            ch_done,
  output logic [NUM_CH-1:0]            ch_err,
  // per-channel stream in
  input  logic [NUM_CH*DATA_WIDTH-1:0] s_tdata,
  input  logic [NUM_CH*KW-1:0]         s_tkeep,
  input  logic [NUM_CH-1:0]            s_tlast,
  input  logic [NUM_CH-1:0]            s_tvalid,
  output logic [NUM_CH-1:0]            s_tready,
  // stream to engine
  output logic [DATA_WIDTH-1:0]        m_tdata,
  output logic [KW-1:0]                m_tkeep,
  output logic                         m_tlast,
  output logic                         m_tvalid,
  input  logic                         m_tready,
  // engine command
  output logic [ADDR_WIDTH-1:0]        dma_addr,
  output logic [31:0]                  dma_size,
  output logic                         dma_eof,
  output logic                         dma_vld,
  input  logic                         dma_rdy,
  input  logic                         dma_err,
  // status
  output logic                         busy,
  output logic [IDW-1:0]               grant_id
);

  state_t                  state_q, state_d;
  logic [IDW-1:0]          grant_q, grant_d;
  logic [IDW-1:0]          last_q, last_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [31:0]             size_q, size_d;
  logic                    eof_q, eof_d;
  logic                    err_q, err_d;
  logic [31:0]             beat_q, beat_d;

  logic [NUM_CH-1:0]       arb_gnt;
  logic [IDW-1:0]          arb_id;
  logic                    arb_any;
  logic                    room;
  logic                    beat_hs;

  logic [DATA_WIDTH-1:0]   s_data_a [NUM_CH];
  logic [KW-1:0]           s_keep_a [NUM_CH];
  logic [ADDR_WIDTH-1:0]   addr_a   [NUM_CH];
  logic [31:0]             size_a   [NUM_CH];

  for (genvar c = 0; c < NUM_CH; c++) begin : g_unpack
    assign s_data_a[c] = s_tdata[c*DATA_WIDTH +: DATA_WIDTH];
    assign s_keep_a[c] = s_tkeep[c*KW +: KW];
    assign addr_a[c]   = req_addr[c*ADDR_WIDTH +: ADDR_WIDTH];
    assign size_a[c]   = req_size[c*32 +: 32];
  end

  rr_arbiter #(
    .N (NUM_CH)
  ) u_arb (
    .req        (req_vld),
    .last       (last_q),
    .gnt_onehot (arb_gnt),
    .gnt_id     (arb_id),
    .any        (arb_any)
  );

  assign dma_addr = addr_q;
  assign dma_size = size_q;
  assign dma_eof  = eof_q;
  assign busy     = (state_q != IDLE);
  assign grant_id = grant_q;
  assign room     = (beat_q < size_q);

  // State and per-transfer context registers.
  // last_q resets to the top channel so the first search begins at channel 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= IDW'(NUM_CH - 1);
      addr_q  <= '0;
      size_q  <= '0;
      eof_q   <= 1'b0;
      err_q   <= 1'b0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      eof_q   <= eof_d;
      err_q   <= err_d;
      beat_q  <= beat_d;
    end
  end

  // Next-state, stream steering and per-channel handshakes.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    last_d   = last_q;
    addr_d   = addr_q;
    size_d   = size_q;
    eof_d    = eof_q;
    err_d    = err_q;
    beat_d   = beat_q;
    req_rdy  = '0;
    s_tready = '0;
    m_tdata  = '0;
    m_tkeep  = '0;
    m_tlast  = 1'b0;
    m_tvalid = 1'b0;
    dma_vld  = 1'b0;
    ch_done  = '0;
    ch_err   = '0;
    beat_hs  = 1'b0;

    case (state_q)
      IDLE: begin
        // req_rdy is combinational on req_vld, so it is also held low by reset.
        if (arb_any && rst_n) begin
          req_rdy = arb_gnt;
          grant_d = arb_id;
          addr_d  = addr_a[arb_id];
          size_d  = size_a[arb_id];
          eof_d   = req_eof[arb_id];
          beat_d  = '0;
          if (size_a[arb_id] == 32'd0) begin
            err_d   = 1'b1;
            state_d = REPORT;
          end else begin
            err_d   = 1'b0;
            state_d = ISSUE;
          end
        end
      end

      ISSUE: begin
        dma_vld = 1'b1;
        if (dma_rdy) begin
          state_d = WAIT_ACK;
        end
      end

      // One cycle only: an engine that has not dropped rdy by now is faulty.
      WAIT_ACK: begin
        if (dma_rdy) begin
          err_d = 1'b1;
        end
        state_d = XFER;
      end

      XFER: begin
        m_tdata            = s_data_a[grant_q];
        m_tkeep            = s_keep_a[grant_q];
        m_tlast            = s_tlast[grant_q];
        m_tvalid           = s_tvalid[grant_q] && room;
        s_tready[grant_q]  = m_tready && room;
        beat_hs            = m_tvalid && m_tready;
        if (beat_hs) begin
          beat_d = beat_q + 32'd1;
          if (eof_q && (s_tlast[grant_q] != (beat_q == size_q - 32'd1))) begin
            err_d = 1'b1;
          end
        end
        // Engine status return; a beat accepted this same cycle still counts.
        if (dma_rdy) begin
          if ((beat_d != size_q) || dma_err) begin
            err_d = 1'b1;
          end
          state_d = REPORT;
        end
      end

      REPORT: begin
        ch_done[grant_q] = 1'b1;
        ch_err[grant_q]  = err_q;
        last_d           = grant_q;
        state_d          = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_dma_wr_sched.sv
// Directed bench for dma_wr_sched: table of single transfers plus hand-written
// zero-size, reset-mid-transfer and round-robin sequences.
module tb_dma_wr_sched;

  localparam int NCH = 4;
  localparam int DW  = 1024;
  localparam int KW  = DW / 8;
  localparam int AW  = 32;

  logic              clk;
  logic              rst_n;
  logic [NCH-1:0]    req_vld;
  logic [NCH-1:0]    req_rdy;
  logic [NCH*AW-1:0] req_addr;
  logic [NCH*32-1:0] req_size;
  logic [NCH-1:0]    req_eof;
  logic [NCH-1:0]    ch_done;
  logic [NCH-1:0]    ch_err;
  logic [NCH*DW-1:0] s_tdata;
  logic [NCH*KW-1:0] s_tkeep;
  logic [NCH-1:0]    s_tlast;
  logic [NCH-1:0]    s_tvalid;
  logic [NCH-1:0]    s_tready;
  logic [DW-1:0]     m_tdata;
  logic [KW-1:0]     m_tkeep;
  logic              m_tlast;
  logic              m_tvalid;
  logic              m_tready;
  logic [AW-1:0]     dma_addr;
  logic [31:0]       dma_size;
  logic              dma_eof;
  logic              dma_vld;
  logic              dma_rdy;
  logic              dma_err;
  logic              busy;
  logic [1:0]        grant_id;

  dma_wr_sched #(
    .NUM_CH     (NCH),
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_vld  (req_vld),
    .req_rdy  (req_rdy),
    .req_addr (req_addr),
    .req_size (req_size),
    .req_eof  (req_eof),
    .ch_done  (ch_done),
    .ch_err   (ch_err),
    .s_tdata  (s_tdata),
    .s_tkeep  (s_tkeep),
    .s_tlast  (s_tlast),
    .s_tvalid (s_tvalid),
    .s_tready (s_tready),
    .m_tdata  (m_tdata),
    .m_tkeep  (m_tkeep),
    .m_tlast  (m_tlast),
    .m_tvalid (m_tvalid),
    .m_tready (m_tready),
    .dma_addr (dma_addr),
    .dma_size (dma_size),
    .dma_eof  (dma_eof),
    .dma_vld  (dma_vld),
    .dma_rdy  (dma_rdy),
    .dma_err  (dma_err),
    .busy     (busy),
    .grant_id (grant_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Source configuration (written by the test) and model observations.
  int src_n     [NCH] = '{default: 0};
  int src_tl    [NCH] = '{default: -1};
  int src_start [NCH] = '{default: 0};
  int src_cons  [NCH] = '{default: 0};
  bit eng_err_cfg = 1'b0;

  int gcount   [NCH] = '{default: 0};
  int done_cnt [NCH] = '{default: 0};
  int gnt_log [$];
  int cur_gnt = 0;
  int cyc = 0, gnt_cyc = 0, done_cyc = 0;
  int fwd_cnt = 0, acc_cnt = 0, data_bad = 0, done_total = 0, err_total = 0;
  logic [AW-1:0]  acc_addr = '0;
  logic [31:0]    acc_size = '0;
  logic [NCH-1:0] last_done_vec = '0;
  logic [NCH-1:0] last_done_err = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Producers, engine model and monitor: sample at negedge, drive 1 after posedge.
  initial begin : model
    bit acc_now;
    int idx, off;
    bit eng_busy;
    int eng_cnt, eng_size, eng_wait, eng_to;
    eng_busy = 1'b0; eng_cnt = 0; eng_size = 0; eng_wait = 0; eng_to = 0;
    s_tdata = '0; s_tkeep = '0; s_tlast = '0; s_tvalid = '0;
    m_tready = 1'b1; dma_rdy = 1'b1; dma_err = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      acc_now = dma_vld && dma_rdy;
      for (int c = 0; c < NCH; c++) begin
        if (req_rdy[c]) begin
          cur_gnt = c;
          gcount[c]++;
          gnt_log.push_back(c);
          gnt_cyc = cyc;
        end
      end
      if (m_tvalid && m_tready) begin
        idx = src_cons[cur_gnt] - src_start[cur_gnt];
        if (m_tdata[31:0] !== {8'(cur_gnt), 24'(idx)} || m_tkeep[7:0] !== 8'(cur_gnt + 1))
          data_bad++;
        fwd_cnt++;
        eng_cnt++;
      end
      for (int c = 0; c < NCH; c++)
        if (s_tvalid[c] && s_tready[c]) src_cons[c]++;
      if (acc_now) begin
        acc_cnt++;
        acc_addr = dma_addr;
        acc_size = dma_size;
      end
      if (|ch_done) begin
        done_total++;
        last_done_vec = ch_done;
        last_done_err = ch_err;
        done_cyc = cyc;
        for (int c = 0; c < NCH; c++) begin
          if (ch_done[c]) begin
            done_cnt[c]++;
            if (ch_err[c]) err_total++;
          end
        end
      end
      @(posedge clk);
      #1;
      if (!rst_n) begin
        dma_rdy = 1'b1; dma_err = 1'b0; eng_busy = 1'b0;
      end else if (acc_now) begin
        dma_rdy = 1'b0; dma_err = 1'b0; eng_busy = 1'b1;
        eng_cnt = 0; eng_size = int'(acc_size); eng_wait = 0; eng_to = 0;
      end else if (eng_busy) begin
        eng_to++;
        if (eng_cnt >= eng_size) eng_wait++;
        if (eng_wait >= 2 || eng_to >= 60) begin
          dma_rdy = 1'b1; dma_err = eng_err_cfg; eng_busy = 1'b0;
        end
      end
      m_tready = (cyc % 4) != 3;
      for (int c = 0; c < NCH; c++) begin
        off = src_cons[c] - src_start[c];
        s_tdata[c*DW +: 32] = {8'(c), 24'(off)};
        s_tkeep[c*KW +: 8]  = 8'(c + 1);
        s_tvalid[c] = off < src_n[c];
        s_tlast[c]  = off == src_tl[c];
      end
    end
  end

  task automatic wait_grant(input int ch, input int g0);
    int n = 0;
    while (gcount[ch] == g0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    check("grant_seen", 64'(gcount[ch] - g0), 64'd1);
  endtask

  task automatic wait_done(input int d0, input int limit);
    int n = 0;
    while (done_total == d0 && n < limit) begin
      @(posedge clk);
      n++;
    end
    check("done_seen", 64'(done_total - d0), 64'd1);
  endtask

  typedef struct {
    int       ch;
    logic [31:0] addr;
    int       size;
    bit       eof;
    int       offer;
    int       tl;
    bit       derr;
    bit       exp_err;
    int       exp_fwd;
  } vec_t;

  vec_t vecs [7];

  initial begin : test
    int f0, a0, b0, d0, c0, e0, base;
    int g0 [NCH];
    int dc0 [NCH];
    int n;

    vecs[0] = '{1, 32'h100, 4, 1'b1, 4, 3, 1'b0, 1'b0, 4};
    vecs[1] = '{0, 32'h200, 8, 1'b1, 8, 5, 1'b0, 1'b1, 8};
    vecs[2] = '{0, 32'h240, 8, 1'b0, 8, 5, 1'b0, 1'b0, 8};
    vecs[3] = '{2, 32'h300, 6, 1'b0, 10, 9, 1'b0, 1'b0, 6};
    vecs[4] = '{3, 32'h400, 2, 1'b0, 2, -1, 1'b1, 1'b1, 2};
    vecs[5] = '{1, 32'h500, 3, 1'b1, 3, -1, 1'b0, 1'b1, 3};
    vecs[6] = '{2, 32'h600, 5, 1'b0, 3, -1, 1'b0, 1'b1, 3};

    rst_n = 1'b0; req_vld = '1; req_addr = '0; req_size = '0; req_eof = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_req_rdy", 64'(req_rdy), 64'd0);
    check("rst_ch_done", 64'(ch_done), 64'd0);
    check("rst_m_tvalid", 64'(m_tvalid), 64'd0);
    check("rst_dma_vld", 64'(dma_vld), 64'd0);
    check("rst_grant_id", 64'(grant_id), 64'd0);
    check("rst_dma_size", 64'(dma_size), 64'd0);
    @(posedge clk); #1;
    req_vld = '0; rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < 7; i++) begin
      f0 = fwd_cnt; a0 = acc_cnt; b0 = data_bad; d0 = done_total;
      c0 = src_cons[vecs[i].ch]; g0[0] = gcount[vecs[i].ch];
      src_start[vecs[i].ch] = src_cons[vecs[i].ch];
      src_n[vecs[i].ch]     = vecs[i].offer;
      src_tl[vecs[i].ch]    = vecs[i].tl;
      eng_err_cfg           = vecs[i].derr;
      req_addr[vecs[i].ch*AW +: AW] = vecs[i].addr;
      req_size[vecs[i].ch*32 +: 32] = 32'(vecs[i].size);
      req_eof[vecs[i].ch]   = vecs[i].eof;
      req_vld[vecs[i].ch]   = 1'b1;
      wait_grant(vecs[i].ch, g0[0]);
      #1 req_vld[vecs[i].ch] = 1'b0;
      wait_done(d0, 400);
      check($sformatf("v%0d_done_vec", i), 64'(last_done_vec), 64'(1 << vecs[i].ch));
      check($sformatf("v%0d_err", i), 64'(last_done_err[vecs[i].ch]), 64'(vecs[i].exp_err));
      check($sformatf("v%0d_accepts", i), 64'(acc_cnt - a0), 64'd1);
      check($sformatf("v%0d_dma_addr", i), 64'(acc_addr), 64'(vecs[i].addr));
      check($sformatf("v%0d_dma_size", i), 64'(acc_size), 64'(vecs[i].size));
      check($sformatf("v%0d_fwd", i), 64'(fwd_cnt - f0), 64'(vecs[i].exp_fwd));
      check($sformatf("v%0d_consumed", i), 64'(src_cons[vecs[i].ch] - c0), 64'(vecs[i].exp_fwd));
      check($sformatf("v%0d_data", i), 64'(data_bad - b0), 64'd0);
      check($sformatf("v%0d_grant_id", i), 64'(grant_id), 64'(vecs[i].ch));
      #1;
      src_n[vecs[i].ch] = 0;
      eng_err_cfg = 1'b0;
      repeat (2) @(posedge clk);
      #1;
    end

    // Zero-size request on ch3: engine untouched, done+err right after the grant.
    a0 = acc_cnt; d0 = done_total; g0[0] = gcount[3];
    req_size[3*32 +: 32] = 32'd0;
    req_vld[3] = 1'b1;
    wait_grant(3, g0[0]);
    #1 req_vld[3] = 1'b0;
    wait_done(d0, 20);
    check("zero_done_vec", 64'(last_done_vec), 64'h8);
    check("zero_err", 64'(last_done_err[3]), 64'd1);
    check("zero_no_dma", 64'(acc_cnt - a0), 64'd0);
    check("zero_latency", 64'((done_cyc - gnt_cyc >= 1) && (done_cyc - gnt_cyc <= 3)), 64'd1);
    repeat (2) @(posedge clk);
    #1;

    // Reset in the middle of a ch1 transfer that is stalled on its source.
    f0 = fwd_cnt; g0[0] = gcount[1];
    src_start[1] = src_cons[1]; src_n[1] = 2; src_tl[1] = -1;
    req_addr[1*AW +: AW] = 32'h700; req_size[1*32 +: 32] = 32'd8; req_eof[1] = 1'b0;
    req_vld[1] = 1'b1;
    wait_grant(1, g0[0]);
    #1 req_vld[1] = 1'b0;
    n = 0;
    while (fwd_cnt - f0 < 1 && n < 100) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("midx_busy_before", 64'(busy), 64'd1);
    rst_n = 1'b0;
    req_vld = '1;
    for (int c = 0; c < NCH; c++) begin
      src_start[c] = src_cons[c]; src_n[c] = 0; src_tl[c] = -1;
      req_size[c*32 +: 32] = 32'd2;
      req_addr[c*AW +: AW] = 32'(c * 32'h1000);
    end
    req_eof = '0;
    @(negedge clk);
    check("midx_busy", 64'(busy), 64'd0);
    check("midx_req_rdy", 64'(req_rdy), 64'd0);
    check("midx_ch_done", 64'(ch_done), 64'd0);
    check("midx_m_tvalid", 64'(m_tvalid), 64'd0);
    check("midx_dma_vld", 64'(dma_vld), 64'd0);
    repeat (2) @(posedge clk);
    #1;

    // Round robin: all four request size 2, three rounds each.
    for (int c = 0; c < NCH; c++) begin
      src_start[c] = src_cons[c]; src_n[c] = 6;
      g0[c] = gcount[c]; dc0[c] = done_cnt[c];
    end
    base = gnt_log.size(); d0 = done_total; e0 = err_total; b0 = data_bad;
    rst_n = 1'b1;
    n = 0;
    while (n < 3000) begin
      @(posedge clk);
      n++;
      if (done_total - d0 >= 12) break;
      #1;
      for (int c = 0; c < NCH; c++) req_vld[c] = (gcount[c] - g0[c]) < 3;
    end
    #1 req_vld = '0;
    check("rr_done_total", 64'(done_total - d0), 64'd12);
    for (int i = 0; i < 12; i++) begin
      if (base + i < gnt_log.size())
        check($sformatf("rr_order%0d", i), 64'(gnt_log[base + i]), 64'(i % 4));
      else
        check($sformatf("rr_order%0d_missing", i), 64'(gnt_log.size()), 64'(base + i + 1));
    end
    for (int c = 0; c < NCH; c++)
      check($sformatf("rr_done_ch%0d", c), 64'(done_cnt[c] - dc0[c]), 64'd3);
    check("rr_errs", 64'(err_total - e0), 64'd0);
    check("rr_data", 64'(data_bad - b0), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
